// File: rtl/adc_emu_pkg.sv
// adc_emu_pkg: shared state type and default sizes for the ADC emulator.
// ADC_EMU_TRIANGLE_EN (optional) selects a triangle sample pattern.
package adc_emu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      HOLD
   } state_t;

   localparam int ADC_DATA_W     = 12;
   localparam int ADC_LEAD_ZEROS = 4;
   localparam int FRAME_W        = ADC_LEAD_ZEROS + ADC_DATA_W;

endpackage

// File: rtl/adc_emu_pattern.sv
// adc_emu_pattern: deterministic sample source, one step per frame.
// Sawtooth by default; triangle when ADC_EMU_TRIANGLE_EN is defined.
module adc_emu_pattern
   import adc_emu_pkg::*;
#(
   parameter int                DATA_W = ADC_DATA_W,
   parameter int unsigned       STEP   = 1,
   parameter logic [DATA_W-1:0] INIT   = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              advance,
   output logic [DATA_W-1:0] value
);

   logic [DATA_W-1:0] r_value;
   logic [DATA_W-1:0] w_next;

`ifdef ADC_EMU_TRIANGLE_EN
   localparam logic [DATA_W:0] L_STEP = STEP[DATA_W:0];
   localparam logic [DATA_W:0] L_MAX  = {1'b0, {DATA_W{1'b1}}};

   logic            r_down;
   logic            w_down_nxt;
   logic [DATA_W:0] w_up_sum;

   // Triangle: saturate at either rail and reverse direction there.
   always_comb begin
      w_next     = r_value;
      w_down_nxt = r_down;
      w_up_sum   = {1'b0, r_value} + L_STEP;
      if (!r_down) begin
         if (w_up_sum >= L_MAX) begin
            w_next     = L_MAX[DATA_W-1:0];
            w_down_nxt = 1'b1;
         end else begin
            w_next = w_up_sum[DATA_W-1:0];
         end
      end else begin
         if ({1'b0, r_value} <= L_STEP) begin
            w_next     = '0;
            w_down_nxt = 1'b0;
         end else begin
            w_next = r_value - L_STEP[DATA_W-1:0];
         end
      end
   end

   // Direction register; counts up out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_down <= 1'b0;
      end else if (advance) begin
         r_down <= w_down_nxt;
      end
   end
`else
   localparam logic [DATA_W-1:0] L_STEP = STEP[DATA_W-1:0];

   // Sawtooth: the modular add wraps at 2^DATA_W by itself.
   always_comb begin
      w_next = r_value + L_STEP;
   end
`endif

   // Current pattern value, stepped once per loaded frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_value <= INIT;
      end else if (advance) begin
         r_value <= w_next;
      end
   end

   assign value = r_value;

endmodule

// File: rtl/adc_emulator.sv
// adc_emulator: serial ADC stand-in, one 16-bit frame per cs falling edge.
// Define ADC_EMU_TRIANGLE_EN for a triangle pattern instead of a sawtooth.
module adc_emulator
   import adc_emu_pkg::*;
#(
   parameter int                DATA_W     = ADC_DATA_W,
   parameter int                LEAD_ZEROS = ADC_LEAD_ZEROS,
   parameter int unsigned       STEP       = 1,
   parameter logic [DATA_W-1:0] INIT       = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs,
   output logic              sdata,
   output logic              sdata_oe,
   output logic              frame_start,
   output logic              frame_done,
   output logic [DATA_W-1:0] sample_out
);

   localparam int L_FRAME_W = LEAD_ZEROS + DATA_W;
   localparam int L_CNT_W   = $clog2(L_FRAME_W + 1);
   localparam logic [L_CNT_W-1:0] L_LAST = L_CNT_W'(L_FRAME_W - 1);
   localparam logic [L_CNT_W-1:0] L_ONE  = L_CNT_W'(1);

   state_t               r_state;
   logic                 r_cs_q;
   logic                 r_armed;
   logic [L_FRAME_W-1:0] r_shreg;
   logic [L_CNT_W-1:0]   r_bit_cnt;
   logic                 r_sdata;
   logic                 r_oe;
   logic                 r_fs;
   logic                 r_fd;
   logic [DATA_W-1:0]    r_sample;

   state_t               w_state_nxt;
   logic [L_FRAME_W-1:0] w_shreg_nxt;
   logic [L_CNT_W-1:0]   w_cnt_nxt;
   logic                 w_sdata_nxt;
   logic                 w_oe_nxt;
   logic                 w_fs_nxt;
   logic                 w_fd_nxt;
   logic [DATA_W-1:0]    w_sample_nxt;
   logic                 w_advance;
   logic                 w_fall;
   logic [DATA_W-1:0]    w_pattern;
   logic [L_FRAME_W-1:0] w_load;

   adc_emu_pattern #(
      .DATA_W (DATA_W),
      .STEP   (STEP),
      .INIT   (INIT)
   ) u_pattern (
      .clk     (clk),
      .reset   (reset),
      .advance (w_advance),
      .value   (w_pattern)
   );

   // cs held low through reset must not count as a falling edge, so
   // an edge is only honoured once cs has been seen high since reset.
   assign w_fall = r_armed & r_cs_q & ~cs;
   assign w_load = {{LEAD_ZEROS{1'b0}}, w_pattern};

   // Next state and outputs; r_shreg holds the not-yet-driven bits MSB-first.
   always_comb begin
      w_state_nxt  = r_state;
      w_shreg_nxt  = r_shreg;
      w_cnt_nxt    = r_bit_cnt;
      w_sdata_nxt  = 1'b0;
      w_oe_nxt     = 1'b0;
      w_fs_nxt     = 1'b0;
      w_fd_nxt     = 1'b0;
      w_sample_nxt = r_sample;
      w_advance    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_fall) begin
               w_shreg_nxt  = {w_load[L_FRAME_W-2:0], 1'b0};
               w_sdata_nxt  = w_load[L_FRAME_W-1];
               w_oe_nxt     = 1'b1;
               w_cnt_nxt    = L_ONE;
               w_sample_nxt = w_pattern;
               w_fs_nxt     = 1'b1;
               w_advance    = 1'b1;
               w_state_nxt  = SHIFT;
            end
         end
         SHIFT: begin
            if (cs) begin
               w_state_nxt = IDLE;
            end else begin
               w_shreg_nxt = {r_shreg[L_FRAME_W-2:0], 1'b0};
               w_sdata_nxt = r_shreg[L_FRAME_W-1];
               w_oe_nxt    = 1'b1;
               w_cnt_nxt   = r_bit_cnt + L_ONE;
               if (r_bit_cnt == L_LAST) begin
                  w_fd_nxt    = 1'b1;
                  w_state_nxt = HOLD;
               end
            end
         end
         HOLD: begin
            if (cs) begin
               w_state_nxt = IDLE;
            end else begin
               w_oe_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, shift register, counter and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cs_q    <= 1'b1;
         r_armed   <= 1'b0;
         r_shreg   <= '0;
         r_bit_cnt <= '0;
         r_sdata   <= 1'b0;
         r_oe      <= 1'b0;
         r_fs      <= 1'b0;
         r_fd      <= 1'b0;
         r_sample  <= INIT;
      end else begin
         r_state   <= w_state_nxt;
         r_cs_q    <= cs;
         r_armed   <= r_armed | cs;
         r_shreg   <= w_shreg_nxt;
         r_bit_cnt <= w_cnt_nxt;
         r_sdata   <= w_sdata_nxt;
         r_oe      <= w_oe_nxt;
         r_fs      <= w_fs_nxt;
         r_fd      <= w_fd_nxt;
         r_sample  <= w_sample_nxt;
      end
   end

   assign sdata       = r_sdata;
   assign sdata_oe    = r_oe;
   assign frame_start = r_fs;
   assign frame_done  = r_fd;
   assign sample_out  = r_sample;

endmodule

// File: tb/tb_adc_emulator.sv
// tb_adc_emulator: vector table plus frame scoreboard for adc_emulator.
// Instance A starts at 0x5A5, instance B at 4094 to cross the wrap point.
module tb_adc_emulator;

   localparam int DW = 12;

   logic clk = 1'b0;
   always #20 clk = ~clk;

   logic          rst_a, cs_a, sd_a, oe_a, fs_a, fd_a;
   logic [DW-1:0] so_a;
   logic          rst_b, cs_b, sd_b, oe_b, fs_b, fd_b;
   logic [DW-1:0] so_b;

   adc_emulator #(
      .DATA_W(12), .LEAD_ZEROS(4), .STEP(1), .INIT(12'h5A5)
   ) u_a (
      .clk(clk), .reset(rst_a), .cs(cs_a), .sdata(sd_a),
      .sdata_oe(oe_a), .frame_start(fs_a), .frame_done(fd_a),
      .sample_out(so_a)
   );

   adc_emulator #(
      .DATA_W(12), .LEAD_ZEROS(4), .STEP(1), .INIT(12'd4094)
   ) u_b (
      .clk(clk), .reset(rst_b), .cs(cs_b), .sdata(sd_b),
      .sdata_oe(oe_b), .frame_start(fs_b), .frame_done(fd_b),
      .sample_out(so_b)
   );

   typedef struct packed {
      logic          cs;
      logic [3:0]    flags;
      logic [DW-1:0] so;
   } vec_t;

   vec_t          tbl [23];
   logic [DW-1:0] sb_q [$];
   int            n_chk = 0;
   int            n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW:0] nxt(input logic [DW-1:0] cur,
                                       input logic dn);
`ifdef ADC_EMU_TRIANGLE_EN
      if (!dn) begin
         if (cur >= 12'd4094) return {1'b1, 12'hFFF};
         return {1'b0, cur + 12'd1};
      end
      if (cur <= 12'd1) return {1'b0, 12'd0};
      return {1'b1, cur - 12'd1};
`else
      return {dn, cur + 12'd1};
`endif
   endfunction

   initial begin
      logic [15:0]   frame_w;
      logic [15:0]   fw;
      logic [14:0]   cap;
      logic [DW-1:0] m_cur;
      logic [DW-1:0] exp_s;
      logic          m_dn;
      int            nfs, nfd, noe, cyc;
      logic          got;

      frame_w = 16'h05A5;
      for (int i = 0; i < 23; i++) begin
         tbl[i].cs    = 1'b1;
         tbl[i].flags = 4'b0000;
         tbl[i].so    = 12'h5A5;
         if (i >= 4 && i <= 20) begin
            int k;
            k = i - 3;
            tbl[i].cs = 1'b0;
            if (k <= 16)
               tbl[i].flags = {frame_w[16-k], 1'b1, k == 1, k == 16};
            else
               tbl[i].flags = 4'b0100;
         end
      end

      rst_a = 1'b1; rst_b = 1'b1; cs_a = 1'b1; cs_b = 1'b1;
      repeat (2) step();
      chk("reset A", 32'({sd_a, oe_a, fs_a, fd_a, so_a}),
          32'({4'b0000, 12'h5A5}));
      chk("reset B", 32'({sd_b, oe_b, fs_b, fd_b, so_b}),
          32'({4'b0000, 12'd4094}));
      rst_a = 1'b0; rst_b = 1'b0;

      for (int i = 0; i < 23; i++) begin
         cs_a = tbl[i].cs;
         step();
         chk($sformatf("frame vec%0d", i),
             32'({sd_a, oe_a, fs_a, fd_a, so_a}),
             32'({tbl[i].flags, tbl[i].so}));
      end

      m_cur = 12'd4094; m_dn = 1'b0; exp_s = '0;
      for (int f = 0; f < 6; f++) begin
         cs_b = 1'b1;
         repeat (3) step();
         sb_q.push_back(m_cur);
         {m_dn, m_cur} = nxt(m_cur, m_dn);
         cs_b = 1'b0; cap = '0; nfs = 0; nfd = 0;
         for (int j = 0; j < 15; j++) begin
            step();
            cap = {cap[13:0], sd_b};
            if (fs_b) begin
               nfs++;
               if (sb_q.size() > 0) begin
                  exp_s = sb_q.pop_front();
                  chk($sformatf("stream sample f%0d", f), 32'(so_b),
                      32'(exp_s));
               end
            end
            if (fd_b) nfd++;
         end
         cs_b = 1'b1;
         fw = {4'b0000, exp_s};
         chk($sformatf("stream word f%0d", f), 32'(cap), 32'(fw[15:1]));
         chk($sformatf("stream pulses f%0d", f), 32'(nfs * 16 + nfd),
             32'd16);
      end
      step();

      rst_a = 1'b1; step(); rst_a = 1'b0;
      m_cur = 12'h5A5; m_dn = 1'b0;
      cs_a = 1'b1;
      repeat (2) step();
      sb_q.push_back(m_cur);
      {m_dn, m_cur} = nxt(m_cur, m_dn);
      cs_a = 1'b0; nfd = 0;
      for (int j = 0; j < 6; j++) begin
         step();
         if (fs_a && sb_q.size() > 0) begin
            exp_s = sb_q.pop_front();
            chk("abort sample", 32'(so_a), 32'(exp_s));
         end
         if (fd_a) nfd++;
      end
      cs_a = 1'b1;
      step();
      chk("abort idle", 32'({sd_a, oe_a, fd_a}), 32'd0);
      chk("abort no done", 32'(nfd), 32'd0);

      sb_q.push_back(m_cur);
      {m_dn, m_cur} = nxt(m_cur, m_dn);
      cs_a = 1'b0;
      for (int j = 0; j < 9; j++) begin
         step();
         if (fs_a && sb_q.size() > 0) begin
            exp_s = sb_q.pop_front();
            chk("after abort sample", 32'(so_a), 32'(exp_s));
         end
      end
      fw = {4'b0000, exp_s};
      chk("bit8 before reset", 32'({sd_a, oe_a}), 32'({fw[7], 1'b1}));
      rst_a = 1'b1;
      #1;
      chk("mid-frame reset", 32'({sd_a, oe_a, fs_a, fd_a, so_a}),
          32'({4'b0000, 12'h5A5}));
      step(); step();
      rst_a = 1'b0;
      m_cur = 12'h5A5; m_dn = 1'b0;
      nfs = 0; noe = 0;
      repeat (20) begin
         step();
         if (fs_a) nfs++;
         if (oe_a) noe++;
      end
      chk("cs low out of reset", 32'(nfs + noe), 32'd0);

      cs_a = 1'b1;
      step();
      sb_q.push_back(m_cur);
      {m_dn, m_cur} = nxt(m_cur, m_dn);
      cs_a = 1'b0; cyc = 0; got = 1'b0;
      for (int j = 0; j < 20 && !got; j++) begin
         step();
         cyc++;
         if (fs_a && sb_q.size() > 0) begin
            exp_s = sb_q.pop_front();
            chk("rearm sample", 32'(so_a), 32'(exp_s));
         end
         if (fd_a) got = 1'b1;
      end
      chk("rearm done cycle", got ? 32'(cyc) : 32'd0, 32'd16);
      step();
      chk("rearm hold", 32'({sd_a, oe_a, fd_a}), 32'b010);
      cs_a = 1'b1;
      step();
      chk("sb drained", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
